byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer.sv | 99 +++++++++
 tb/tb_byte_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// Packs an upstream byte stream little-endian into 32-bit words with byte keeps,
// buffered in a DEPTH-entry FIFO whose head is held in output registers.
module byte_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               data_in,
    input  logic                     valid,
    input  logic                     flush,
    output logic [31:0]              out_data,
    output logic [3:0]               out_keep,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } word_t;

    word_t           mem [DEPTH];
    logic [1:0]      cnt;
    logic [31:0]     acc;
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
    logic [LW-1:0]   level_next;
    logic [2:0]      fill;
    word_t           push_word, head_next;
    logic            push, push_ok, pop, full;

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && out_ready;

    always_comb begin
        fill           = {1'b0, cnt} + {2'b00, valid};
        push_word.data = acc;
        if (valid)
            push_word.data[{cnt, 3'b000} +: 8] = data_in;
        case (fill)
            3'd1:    push_word.keep = 4'b0001;
            3'd2:    push_word.keep = 4'b0011;
            3'd3:    push_word.keep = 4'b0111;
            default: push_word.keep = 4'b1111;
        endcase
        push    = (valid && cnt == 2'd3) || (flush && fill != 3'd0);
        // A full FIFO still accepts when the same edge frees a slot.
        push_ok = push && (!full || pop);
        rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;
        case ({push_ok, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
        // The next head may be the word being written on this very edge.
        head_next = (push_ok && wr_ptr == rd_next) ? push_word : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            out_data <= '0;
            out_keep <= '0;
        end else begin
            if (push) begin
                cnt <= '0;
                acc <= '0;
            end else if (valid) begin
                cnt                     <= cnt + 2'd1;
                acc[{cnt, 3'b000} +: 8] <= data_in;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && !push_ok)
                overflow <= 1'b1;
            rd_ptr <= rd_next;
            level  <= level_next;
            // Head registers hold their last value once the FIFO drains.
            if (level_next != '0) begin
                out_data <= head_next.data;
                out_keep <= head_next.keep;
            end
        end
    end
endmodule

// File: tb/tb_byte_packer.sv
// Directed self-checking bench for byte_packer (DEPTH = 4).
module tb_byte_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    byte_packer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid(valid), .flush(flush),
        .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Inputs are applied, one edge taken, outputs sampled 1 time unit later.
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        valid = v; data_in = d; flush = f; out_ready = r;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1'b1, 8'h5A, 1'b1, 1'b1);
        step(1'b1, 8'h5B, 1'b1, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_chk++; if (out_keep !== 4'h0) begin n_fail++; $display("FAIL reset_keep got %b want 0000", out_keep); end
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        reset = 1'b1;
    endtask

    task automatic test_full_word();
        step(1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b0, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL word_early got %b want 0", out_valid); end
        step(1'b1, 8'h44, 1'b0, 1'b1);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL word_valid got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'h44332211) begin n_fail++; $display("FAIL word_data got %h want 44332211", out_data); end
        n_chk++; if (out_keep !== 4'b1111) begin n_fail++; $display("FAIL word_keep got %b want 1111", out_keep); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL word_once got %b want 0", out_valid); end
        n_chk++; if (out_data !== 32'h44332211) begin n_fail++; $display("FAIL word_hold got %h want 44332211", out_data); end
    endtask

    task automatic test_flush();
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL flush_data got %h want 0000bbaa", out_data); end
        n_chk++; if (out_keep !== 4'b0011) begin n_fail++; $display("FAIL flush_keep got %b want 0011", out_keep); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %b want 0", out_valid); end
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL flush_empty_lvl got %0d want 0", level); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        n_chk++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", level); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_chk++; if (out_data !== 32'h03020100) begin n_fail++; $display("FAIL ovf_stable got %h want 03020100", out_data); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                n_fail++; $display("FAIL ovf_drain%0d got v=%b %h want v=1 %h", i, out_valid, out_data, exp[i]); end
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL ovf_drained got %0d want 0", level); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp [4] = '{32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h23222120};
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        n_chk++; if (level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fp_full got lvl=%0d ovf=%b want 4 0", level, overflow); end
        step(1'b1, 8'h23, 1'b0, 1'b1);
        n_chk++; if (level !== 3'd4) begin n_fail++; $display("FAIL fp_level got %0d want 4", level); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_keep !== 4'b1111) begin
                n_fail++; $display("FAIL fp_drain%0d got v=%b %h %b want v=1 %h 1111", i, out_valid, out_data, out_keep, exp[i]); end
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'hEF, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 8'hF0, 1'b1, 1'b1);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_early got %b want 0", out_valid); end
        step(1'b1, 8'h04, 1'b0, 1'b0);
        n_chk++; if (level !== 3'd1) begin n_fail++; $display("FAIL rm_level got %0d want 1", level); end
        n_chk++; if (out_data !== 32'h04030201 || out_keep !== 4'b1111) begin
            n_fail++; $display("FAIL rm_word got %h %b want 04030201 1111", out_data, out_keep); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_single got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [4] = '{32'hA4A3A2A1, 32'h00006655, 32'h00000077, 32'h00838281};
        logic [3:0]  exp_k [4] = '{4'b1111, 4'b0011, 4'b0001, 4'b0111};
        do_reset();
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0);
        step(1'b1, 8'hA4, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_chk++; if (level !== 3'd1) begin n_fail++; $display("FAIL b2b_vf4 got lvl %0d want 1", level); end
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b1, 8'h81, 1'b0, 1'b0);
        step(1'b1, 8'h82, 1'b0, 1'b0);
        step(1'b1, 8'h83, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_chk++; if (level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL b2b_level got %0d ovf=%b want 4 0", level, overflow); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (out_data !== exp_d[i] || out_keep !== exp_k[i]) begin
                n_fail++; $display("FAIL b2b_drain%0d got %h %b want %h %b", i, out_data, out_keep, exp_d[i], exp_k[i]); end
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL b2b_end got %0d want 0", level); end
    endtask

    initial begin
        reset = 1'b0; valid = 1'b0; flush = 1'b0; data_in = '0; out_ready = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
